elastic_pipeline_register: RTL and testbench
============================================

// Module: elastic_pipeline_register
// PURPOSE
// Parametrised elastic pipeline stage with valid/ready handshaking, used between any two pipeline
// stages (IF/ID .. MEM/WB) in place of fixed per-stage registers. Carries a control-enable field
// (forced to 0, the safe value, on reset/flush/empty) and a data payload. Latency is 1 cycle.
// Stalls propagate by backpressure instead of a global stall line.
// PARAMETERS
// DATA_W   32  payload width (ALU result, PC+4, RD, selects ...)
// CTRL_W   1   enable-bit width (REG_W_En, MEM_W_En ...); zeroed whenever output is invalid
// SKID     1   1: 2-entry skid buffer, registered In_Ready; 0: 1-entry, combinational In_Ready
// PORTS
// CLK        in   1        clock, all state updates on posedge
// RST        in   1        synchronous reset, active-low (RST==0 resets on posedge CLK)
// FLUSH      in   1        synchronous flush: discard all held entries (branch mispredict)
// In_Valid   in   1        upstream has an entry this cycle
// In_Ready   out  1        stage accepts an entry this cycle; in_fire = In_Valid & In_Ready
// In_Ctrl    in   CTRL_W   upstream enables
// In_Data    in   DATA_W   upstream payload
// Out_Valid  out  1        Out_Ctrl/Out_Data hold a valid entry
// Out_Ready  in   1        downstream consumes; out_fire = Out_Valid & Out_Ready
// Out_Ctrl   out  CTRL_W   enables of head entry; 0 when Out_Valid==0
// Out_Data   out  DATA_W   payload of head entry
// Occupancy  out  2        entries held (0..2; max 1 when SKID=0)
// BEHAVIOUR
// - Reset (RST==0 at posedge): state EMPTY, Out_Valid=0, Out_Ctrl=0, Out_Data=0, skid entry=0,
//   Occupancy=0; In_Ready=1 from the first cycle after reset. Reset overrides FLUSH and inputs.
// - Storage: main reg (drives outputs), skid reg (SKID=1 only). Outputs are registered, no comb path In_*->Out_*.
// - States (SKID=1): EMPTY(occ 0), BUSY(occ 1), FULL(occ 2). In_Ready = (state != FULL), registered.
//   EMPTY: in_fire -> BUSY, main<=In.
//   BUSY : in_fire&out_fire -> BUSY, main<=In; in_fire&!out_fire -> FULL, skid<=In;
//          !in_fire&out_fire -> EMPTY; neither -> hold.
//   FULL : out_fire -> BUSY, main<=skid; else hold. In_Valid ignored (In_Ready=0).
// - SKID=0: states EMPTY/BUSY only; In_Ready = !Out_Valid | Out_Ready (combinational from Out_Ready).
//   BUSY & in_fire & out_fire -> BUSY, main<=In; out_fire only -> EMPTY.
// - Ordering strictly FIFO; no entry dropped or duplicated except by FLUSH/reset.
// - FLUSH=1 (RST==1): next state EMPTY, Out_Ctrl and skid ctrl <=0, Out_Data holds last value;
//   an in_fire in the same cycle is discarded (flush wins). In_Ready in the flush cycle follows
//   the normal rule; it is 1 on the following cycle.
// - EMPTY: Out_Valid=0, Out_Ctrl=0, Out_Data holds last dequeued value (0 after reset).
// - Throughput 1 entry/cycle sustained in both modes when Out_Ready==1.
// - Occupancy = 0/1/2 matching state; updates same edge as state.
// TESTING
// 1 Reset: RST=0 one cycle with In_Valid=1 -> Out_Valid=0, Out_Ctrl=0, Out_Data=0, Occupancy=0, In_Ready=1.
// 2 Stream: Out_Ready=1, send D=0x10,0x11,0x12 back-to-back -> each appears 1 cycle later, Out_Valid=1 throughout.
// 3 Backpressure SKID=1: Out_Ready=0, send 0xA,0xB,0xC -> Occupancy 2, In_Ready=0, 0xC held upstream;
//   Out_Ready=1 -> 0xA,0xB,0xC emerge in order, no loss.
// 4 Flush in FULL with In_Valid=1 (0xD, Ctrl=1) -> next cycle Out_Valid=0, Out_Ctrl=0,
//   Occupancy 0; 0xD never appears at output.
// 5 SKID=0: Out_Ready=0 while BUSY -> In_Ready=0 same cycle; Out_Ready=1 -> In_Ready=1 same cycle, 1/cycle rate.
// 6 Reset mid-FULL with random traffic -> state EMPTY next cycle; scoreboard assertions
//   (ordering, Out_Ctrl==0 when !Out_Valid) hold over 1000 random cycles per mode.

Source files
------------

// File: rtl/elastic_pipeline_register.sv
// Elastic pipeline stage: valid/ready handshake, registered outputs, optional skid entry.
// SKID=1 keeps a second entry so In_Ready can come straight from state (no Out_Ready path);
// SKID=0 holds a single entry and lets In_Ready follow Out_Ready in the same cycle.
module elastic_pipeline_register #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 1,
    parameter int SKID   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FLUSH,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data,
    output logic [1:0]        Occupancy
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
    logic [DATA_W-1:0] main_data_q, skid_data_q;

    logic in_fire, out_fire;
    logic ld_main_in, ld_main_skid, ld_skid, clr_main_ctrl;

    assign in_fire  = In_Valid & In_Ready;
    assign out_fire = Out_Valid & Out_Ready;

    // State register; reset wins over flush and traffic.
    always_ff @(posedge CLK) begin
        if (!RST) state_q <= ST_EMPTY;
        else      state_q <= state_d;
    end

    // Next state plus the datapath load strobes for this transition.
    always_comb begin
        state_d       = state_q;
        ld_main_in    = 1'b0;
        ld_main_skid  = 1'b0;
        ld_skid       = 1'b0;
        clr_main_ctrl = 1'b0;
        if (FLUSH) begin
            // Any in_fire this cycle is dropped: no load strobe is raised.
            state_d       = ST_EMPTY;
            clr_main_ctrl = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d    = ST_BUSY;
                        ld_main_in = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        ld_main_in = 1'b1;
                    end else if (in_fire) begin
                        // Only reachable with a skid entry; SKID=0 deasserts In_Ready here.
                        if (SKID != 0) begin
                            state_d = ST_FULL;
                            ld_skid = 1'b1;
                        end
                    end else if (out_fire) begin
                        state_d       = ST_EMPTY;
                        clr_main_ctrl = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d      = ST_BUSY;
                        ld_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_d       = ST_EMPTY;
                    clr_main_ctrl = 1'b1;
                end
            endcase
        end
    end

    // Entry storage; data is left alone when emptying so Out_Data shows the last entry.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            if (ld_main_in) begin
                main_ctrl_q <= In_Ctrl;
                main_data_q <= In_Data;
            end else if (ld_main_skid) begin
                main_ctrl_q <= skid_ctrl_q;
                main_data_q <= skid_data_q;
            end else if (clr_main_ctrl) begin
                main_ctrl_q <= '0;
            end
            if (ld_skid) begin
                skid_ctrl_q <= In_Ctrl;
                skid_data_q <= In_Data;
            end else if (FLUSH) begin
                skid_ctrl_q <= '0;
            end
        end
    end

    // Status outputs decoded from state (and Out_Ready for the single-entry variant).
    always_comb begin
        Out_Valid = (state_q != ST_EMPTY);
        Occupancy = state_q;
        if (SKID != 0) In_Ready = (state_q != ST_FULL);
        else           In_Ready = (state_q == ST_EMPTY) | Out_Ready;
    end

    assign Out_Ctrl = main_ctrl_q;
    assign Out_Data = main_data_q;

endmodule

// File: tb/tb_elastic_pipeline_register.sv
// Bench for elastic_pipeline_register: drives a SKID=1 and a SKID=0 instance with the same
// stimulus and compares each against its own FIFO-with-capacity reference every cycle.
module tb_elastic_pipeline_register;

    logic        CLK = 1'b0;
    logic        RST, FLUSH, In_Valid, Out_Ready;
    logic [0:0]  In_Ctrl;
    logic [31:0] In_Data;

    logic [1:0]       o_rdy, o_valid, o_ctrl;
    logic [1:0][31:0] o_data;
    logic [1:0][1:0]  o_occ;

    int n_vec = 0;
    int n_err = 0;

    // Reference: index 1 = SKID=1 (capacity 2), index 0 = SKID=0 (capacity 1).
    logic [31:0] mdat  [2][2];
    logic        mctl  [2][2];
    int          mcnt  [2];
    logic [31:0] mlast [2];

    always #5 CLK = ~CLK;

    elastic_pipeline_register #(.DATA_W(32), .CTRL_W(1), .SKID(1)) u_skid1 (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .In_Valid(In_Valid), .In_Ready(o_rdy[1]), .In_Ctrl(In_Ctrl), .In_Data(In_Data),
        .Out_Valid(o_valid[1]), .Out_Ready(Out_Ready), .Out_Ctrl(o_ctrl[1:1]),
        .Out_Data(o_data[1]), .Occupancy(o_occ[1])
    );

    elastic_pipeline_register #(.DATA_W(32), .CTRL_W(1), .SKID(0)) u_skid0 (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .In_Valid(In_Valid), .In_Ready(o_rdy[0]), .In_Ctrl(In_Ctrl), .In_Data(In_Data),
        .Out_Valid(o_valid[0]), .Out_Ready(Out_Ready), .Out_Ctrl(o_ctrl[0:0]),
        .Out_Data(o_data[0]), .Occupancy(o_occ[0])
    );

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, check both instances, then advance the reference.
    task automatic step(input logic rst, input logic fl, input logic iv, input logic ic,
                        input logic [31:0] id, input logic ordy);
        logic exp_rdy, in_f, out_f;
        RST = rst; FLUSH = fl; In_Valid = iv; In_Ctrl = ic; In_Data = id; Out_Ready = ordy;
        #1;
        for (int m = 0; m < 2; m++) begin
            exp_rdy = (m == 1) ? (mcnt[m] < 2) : (mcnt[m] == 0 || ordy);
            chk($sformatf("m%0d_in_ready", m), {32'd0, o_rdy[m]}, {32'd0, exp_rdy});
            chk($sformatf("m%0d_out_valid", m), {32'd0, o_valid[m]}, {32'd0, mcnt[m] > 0});
            chk($sformatf("m%0d_out_ctrl", m), {32'd0, o_ctrl[m]},
                {32'd0, (mcnt[m] > 0) ? mctl[m][0] : 1'b0});
            chk($sformatf("m%0d_out_data", m), {1'b0, o_data[m]},
                {1'b0, (mcnt[m] > 0) ? mdat[m][0] : mlast[m]});
            chk($sformatf("m%0d_occupancy", m), {31'd0, o_occ[m]}, 33'(mcnt[m]));

            in_f  = iv && exp_rdy;
            out_f = (mcnt[m] > 0) && ordy;
            if (!rst) begin
                mcnt[m]  = 0;
                mlast[m] = '0;
            end else if (fl) begin
                if (mcnt[m] > 0) mlast[m] = mdat[m][0];
                mcnt[m] = 0;
            end else begin
                if (out_f) begin
                    mlast[m]   = mdat[m][0];
                    mdat[m][0] = mdat[m][1];
                    mctl[m][0] = mctl[m][1];
                    mcnt[m]--;
                end
                if (in_f) begin
                    mdat[m][mcnt[m]] = id;
                    mctl[m][mcnt[m]] = ic;
                    mcnt[m]++;
                end
            end
        end
        @(negedge CLK);
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            mcnt[m] = 0; mlast[m] = '0;
            for (int k = 0; k < 2; k++) begin mdat[m][k] = '0; mctl[m][k] = 1'b0; end
        end
        // Power-up reset; state is unknown before this edge so nothing is compared yet.
        RST = 1'b0; FLUSH = 1'b0; In_Valid = 1'b1; In_Ctrl = 1'b1; In_Data = 32'h55;
        Out_Ready = 1'b0;
        @(negedge CLK);

        // Reset with traffic present must leave the stage empty and ready.
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h66, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Back-to-back stream with the consumer always ready.
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h11, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h12, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Backpressure: 0xC is held upstream until there is room.
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'hA, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'hB, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'hC, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'hC, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'hC, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'hC, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Flush while full, with a competing input that must be discarded.
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h2, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hD, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Consumer stalls and releases; single-entry ready follows Out_Ready directly.
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h21, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h21, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h22, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h23, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Reset while full with input pending.
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h30, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h31, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h32, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 1000; i++) begin
            step($urandom_range(0, 99) != 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 3) != 0, 1'($urandom), $urandom,
                 $urandom_range(0, 2) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
